// File: rtl/rib_pkg.sv
// rtl/rib_pkg.sv - RIB bus widths, master ID type and master ID constants
package rib_pkg;

    localparam int RIB_DATA_W = 32;
    localparam int RIB_MASK_W = 4;

    typedef logic [0:0] rib_mst_id_t;

    localparam rib_mst_id_t M0 = 1'b0;
    localparam rib_mst_id_t M1 = 1'b1;

endpackage

// File: rtl/rib_id_fifo.sv
// rtl/rib_id_fifo.sv - in-order FIFO of outstanding master IDs with same-cycle push/pop
module rib_id_fifo
    import rib_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  rib_mst_id_t push_id,
    input  logic        pop,
    output rib_mst_id_t head_id,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rib_mst_id_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO may still accept a push alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rib_arb2.sv
// rtl/rib_arb2.sv - two-master RIB arbiter with in-order response routing (optional RIB_ARB_RR_EN)
module rib_arb2
    import rib_pkg::*;
#(
    parameter int OUTST_DEPTH = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [ADDR_W-1:0]     i_m0_addr,
    input  logic                  i_m0_wrcs,
    input  logic [RIB_MASK_W-1:0] i_m0_mask,
    input  logic [RIB_DATA_W-1:0] i_m0_wdata,
    input  logic                  i_m0_req,
    output logic                  o_m0_gnt,
    output logic                  o_m0_rsp,
    output logic [RIB_DATA_W-1:0] o_m0_rdata,
    input  logic                  i_m0_rdy,
    input  logic [ADDR_W-1:0]     i_m1_addr,
    input  logic                  i_m1_wrcs,
    input  logic [RIB_MASK_W-1:0] i_m1_mask,
    input  logic [RIB_DATA_W-1:0] i_m1_wdata,
    input  logic                  i_m1_req,
    output logic                  o_m1_gnt,
    output logic                  o_m1_rsp,
    output logic [RIB_DATA_W-1:0] o_m1_rdata,
    input  logic                  i_m1_rdy,
    output logic [ADDR_W-1:0]     o_s_addr,
    output logic                  o_s_wrcs,
    output logic [RIB_MASK_W-1:0] o_s_mask,
    output logic [RIB_DATA_W-1:0] o_s_wdata,
    output logic                  o_s_req,
    input  logic                  i_s_gnt,
    input  logic                  i_s_rsp,
    input  logic [RIB_DATA_W-1:0] i_s_rdata,
    output logic                  o_s_rdy
);

    rib_mst_id_t           winner;
    rib_mst_id_t           head_id;
    rib_mst_id_t           hold_id;
    rib_mst_id_t           rsp_id;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_rdy;
    logic                  hold_rdy;
    logic                  hold_valid;
    logic [RIB_DATA_W-1:0] hold_data;
    logic                  can_issue;
    logic                  winner_req;
    logic                  s_req;
    logic                  handshake;
    logic                  s_rdy;
    logic                  pop;
    logic                  live_rsp;
    logic                  rsp_valid;

`ifdef RIB_ARB_RR_EN
    rib_mst_id_t last_winner;

    // On contention the master that did not win the last handshake goes first.
    assign winner = (i_m0_req & ~(i_m1_req & (last_winner == M0))) ? M0 : M1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_winner <= M1;
        end else if (handshake) begin
            last_winner <= winner;
        end
    end
`else
    assign winner = i_m0_req ? M0 : M1;
`endif

    assign winner_req = (winner == M0) ? i_m0_req : i_m1_req;
    assign head_rdy   = (head_id == M0) ? i_m0_rdy : i_m1_rdy;
    assign hold_rdy   = (hold_id == M0) ? i_m0_rdy : i_m1_rdy;

    // A response about to stall into the hold buffer also blocks issue, so 1-cycle slaves never see rdy=0.
    assign can_issue = ~fifo_full & ~hold_valid & ~(i_s_rsp & ~head_rdy);
    assign s_req     = winner_req & can_issue;
    assign handshake = s_req & i_s_gnt;
    assign s_rdy     = ~hold_valid;
    assign pop       = i_s_rsp & s_rdy;
    assign live_rsp  = pop & ~fifo_empty;

    rib_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .push    (handshake),
        .push_id (winner),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hold_valid <= 1'b0;
            hold_id    <= M0;
            hold_data  <= '0;
        end else if (hold_valid) begin
            if (hold_rdy) begin
                hold_valid <= 1'b0;
            end
        end else if (live_rsp & ~head_rdy) begin
            hold_valid <= 1'b1;
            hold_id    <= head_id;
            hold_data  <= i_s_rdata;
        end
    end

    assign rsp_valid = hold_valid | live_rsp;
    assign rsp_id    = hold_valid ? hold_id : head_id;

    // Every output is forced low while reset is asserted, independent of the clock.
    always_comb begin
        o_s_req   = i_rstn & s_req;
        o_s_rdy   = i_rstn & s_rdy;
        o_m0_gnt  = i_rstn & handshake & (winner == M0);
        o_m1_gnt  = i_rstn & handshake & (winner == M1);
        o_m0_rsp  = i_rstn & rsp_valid & (rsp_id == M0);
        o_m1_rsp  = i_rstn & rsp_valid & (rsp_id == M1);
        o_s_addr  = '0;
        o_s_wrcs  = 1'b0;
        o_s_mask  = '0;
        o_s_wdata = '0;
        o_m0_rdata = '0;
        o_m1_rdata = '0;
        if (i_rstn) begin
            o_s_addr   = (winner == M0) ? i_m0_addr  : i_m1_addr;
            o_s_wrcs   = (winner == M0) ? i_m0_wrcs  : i_m1_wrcs;
            o_s_mask   = (winner == M0) ? i_m0_mask  : i_m1_mask;
            o_s_wdata  = (winner == M0) ? i_m0_wdata : i_m1_wdata;
            o_m0_rdata = (hold_valid && hold_id == M0) ? hold_data : i_s_rdata;
            o_m1_rdata = (hold_valid && hold_id == M1) ? hold_data : i_s_rdata;
        end
    end

    // A response with no outstanding ID has nowhere to go and is dropped.
    assert property (@(posedge i_clk) disable iff (!i_rstn) !(i_s_rsp && s_rdy && fifo_empty));

endmodule
